// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request, redirect flush, stall hold.
// Optional FETCH_PERF_EN adds fetch_count / redirect_count outputs.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        align_fault
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] redirect_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_addr;
    logic        r_req;
    logic        r_inst_valid;
    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;
    logic        r_align_fault;

    logic        w_redirect;
    logic [31:0] w_raw_tgt;
    logic [31:0] w_tgt;
    logic        w_accept;
    logic        w_consume;
    logic [31:0] w_addr_inc;

    assign w_redirect = br_taken | jump | jr;
    assign w_raw_tgt  = br_taken ? br_target : (jump ? jump_target : jr_target);
    assign w_tgt      = {w_raw_tgt[31:2], 2'b00};
    assign w_accept   = w_redirect && (r_state != S_IDLE);
    assign w_consume  = r_inst_valid && !stall;
    assign w_addr_inc = r_addr + 32'd4;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_addr        <= RESET_PC;
            r_req         <= 1'b0;
            r_inst_valid  <= 1'b0;
            r_inst        <= 32'd0;
            r_inst_pc     <= 32'd0;
            r_align_fault <= 1'b0;
        end else begin
            if (w_accept && (w_raw_tgt[1:0] != 2'b00))
                r_align_fault <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    r_state <= S_REQ;
                    r_req   <= 1'b1;
                    r_addr  <= r_pc;
                end
                S_REQ: begin
                    if (w_redirect) begin
                        r_pc         <= w_tgt;
                        r_inst_valid <= 1'b0;
                        // Without an ack the old request stays on the bus until it completes.
                        if (imem_ack)
                            r_addr <= w_tgt;
                        else
                            r_state <= S_DROP;
                    end else if (imem_ack) begin
                        r_inst       <= imem_rdata;
                        r_inst_pc    <= r_addr;
                        r_inst_valid <= 1'b1;
                        r_pc         <= w_addr_inc;
                        if (stall) begin
                            r_state <= S_HOLD;
                            r_req   <= 1'b0;
                        end else begin
                            r_addr <= w_addr_inc;
                        end
                    end else if (w_consume) begin
                        r_inst_valid <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (w_redirect) begin
                        r_pc         <= w_tgt;
                        r_addr       <= w_tgt;
                        r_req        <= 1'b1;
                        r_inst_valid <= 1'b0;
                        r_state      <= S_REQ;
                    end else if (!stall) begin
                        r_addr       <= r_pc;
                        r_req        <= 1'b1;
                        r_inst_valid <= 1'b0;
                        r_state      <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (w_redirect)
                        r_pc <= w_tgt;
                    if (imem_ack) begin
                        r_addr  <= w_redirect ? w_tgt : r_pc;
                        r_state <= S_REQ;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_redirect_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_fetch_count    <= 32'd0;
            r_redirect_count <= 32'd0;
        end else begin
            if (w_consume)
                r_fetch_count <= r_fetch_count + 32'd1;
            if (w_accept)
                r_redirect_count <= r_redirect_count + 32'd1;
        end
    end

    assign fetch_count    = r_fetch_count;
    assign redirect_count = r_redirect_count;
`endif

    assign imem_req    = r_req;
    assign imem_addr   = r_addr;
    assign inst_valid  = r_inst_valid;
    assign inst        = r_inst;
    assign inst_pc     = r_inst_pc;
    assign align_fault = r_align_fault;

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC loaded on reset (word aligned).
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 reset  in  1  reset, synchronous, active-low.
REQ-004 br_taken  in  1; br_target  in  32  resolved taken branch and its target.
REQ-005 jump  in  1; jump_target  in  32  direct jump/jal and its target.
REQ-006 jr  in  1; jr_target  in  32  register jump and its target.
REQ-007 stall  in  1  downstream cannot accept the presented instruction.
REQ-008 imem_req  out  1; imem_addr  out  32  instruction memory request and word address.
REQ-009 imem_ack  in  1; imem_rdata  in  32  memory completion strobe and data (latency >= 1 cycle).
REQ-010 inst_valid  out  1; inst  out  32; inst_pc  out  32  instruction presented downstream.
REQ-011 align_fault  out  1  sticky flag, misaligned redirect target seen.

Function
REQ-012 FSM states SHALL be IDLE, REQ, HOLD, DROP; IDLE entered only from reset.
REQ-013 IDLE SHALL move to REQ on the next cycle, driving imem_req=1, imem_addr=PC.
REQ-014 imem_addr SHALL remain stable while imem_req=1 and imem_ack=0.
REQ-015 Redirect = br_taken|jump|jr; priority br_taken > jump > jr; target bits [1:0] forced to 0.
REQ-016 Nonzero target bits [1:0] on the selected redirect SHALL set align_fault until reset.
REQ-017 REQ, imem_ack=1, no redirect, stall=0: inst<=imem_rdata, inst_pc<=imem_addr, inst_valid=1 next cycle, PC<=imem_addr+4, new request issued same cycle as inst_valid (back-to-back, 1 instruction per ack).
REQ-018 REQ, imem_ack=1, no redirect, stall=1: capture as REQ-017, enter HOLD; no new request while in HOLD.
REQ-019 HOLD: inst/inst_pc/inst_valid=1 held; on stall=0 consumed, return to REQ with PC+4 next cycle.
REQ-020 inst_valid SHALL be a one-cycle pulse per instruction unless held by stall; consumption = inst_valid & !stall.
REQ-021 Redirect in REQ with imem_ack=1: data discarded, inst_valid stays 0, PC<=target, REQ issues target next cycle.
REQ-022 Redirect in REQ with imem_ack=0: PC<=target, enter DROP; imem_req and imem_addr held.
REQ-023 DROP: on imem_ack discard data, enter REQ with target; later redirects in DROP overwrite the target (newest wins).
REQ-024 Redirect in HOLD: held instruction dropped, inst_valid=0 next cycle, PC<=target, REQ.
REQ-025 PC arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0 silently.

Reset
REQ-026 reset=0 at any edge, incl. mid-request: state=IDLE, PC=RESET_PC, imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, align_fault=0.
REQ-027 imem_ack arriving in or after reset for a pre-reset request SHALL be ignored.

Configuration
REQ-028 Macro FETCH_PERF_EN defined: adds outputs fetch_count[31:0] (+1 per consumed instruction) and redirect_count[31:0] (+1 per accepted redirect), both 0 on reset, wrapping at 2^32.
REQ-029 FETCH_PERF_EN undefined: those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-030 Reset release, RESET_PC=0, ack 1 cycle after each req, stall=0 -> imem_addr 0,4,8,12; inst_pc matches; inst_valid 1 instruction per ack.
REQ-031 stall=1 for 3 cycles on instruction at 0x8 -> inst/inst_pc=0x8 held 4 cycles, no req for 0xC until stall=0.
REQ-032 br_taken=1 target 0x40 and jump=1 target 0x80 same cycle as ack of 0x10 -> 0x10 never valid, next imem_addr=0x40.
REQ-033 jr target 0x103 while request at 0x20 pending, ack 3 cycles later -> imem_addr held 0x20, data dropped, next imem_addr=0x100, align_fault=1.
REQ-034 reset=0 during outstanding request then ack arrives -> inst_valid=0, restart at RESET_PC.
REQ-035 FETCH_PERF_EN build, 5 consumed instructions and 2 redirects -> fetch_count=5, redirect_count=2.
